alu_result_buffer: RTL and testbench
====================================

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of result entries buffered; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter DATA_W, default 16, width of the result word.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning the adder/subtractor result on in_* is presented.
REQ-006 SHALL have port in_ready, output, 1, meaning the buffer accepts a result this cycle.
REQ-007 SHALL have port in_sum, input, DATA_W, the sum/difference from the adder/subtractor.
REQ-008 SHALL have port in_carry, input, 1, the carry/borrow status.
REQ-009 SHALL have port in_overflow, input, 1, the signed overflow status.
REQ-010 SHALL have port out_valid, output, 1, meaning the head entry is presented.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer takes the head entry.
REQ-012 SHALL have port out_result, output, DATA_W, the head result word.
REQ-013 SHALL have port out_flags, output, 4, the head flags {N,Z,C,V}, with bit 3 = N and bit 0 = V.
REQ-014 SHALL have port count, output, log2(DEPTH)+1, the number of occupied entries.
REQ-015 SHALL have port clr_sticky, input, 1, the synchronous clear of sticky_v.
REQ-016 SHALL have port sticky_v, output, 1, the accumulated overflow indication.

Function
REQ-017 SHALL accept an entry on a clock edge where in_valid and in_ready are both 1 (push), and SHALL ignore in_* otherwise.
REQ-018 SHALL drive in_ready = (count < DEPTH), combinationally from state only and never from in_valid or out_ready.
REQ-019 SHALL compute the flags at push: Z = (in_sum == 0), N = in_sum[DATA_W-1], C = in_carry, V = in_overflow.
REQ-020 SHALL store the result word and the four flags per entry and deliver entries in FIFO order.
REQ-021 SHALL drive out_valid = (count != 0), and SHALL drive out_result and out_flags from the head entry when out_valid = 1, and 0 otherwise.
REQ-022 SHALL pop the head entry on a clock edge where out_valid and out_ready are both 1.
REQ-023 SHALL have one cycle of latency: an entry pushed into an empty buffer is visible with out_valid = 1 after that edge.
REQ-024 SHALL, on simultaneous push and pop, leave count unchanged and advance both the write and read pointers.
REQ-025 SHALL, when full, deassert in_ready even if out_ready = 1 in the same cycle; there is no bypass.
REQ-026 SHALL, when empty, have out_ready no effect on state.
REQ-027 SHALL wrap the pointers modulo DEPTH with no entry loss or duplication.
REQ-028 SHALL hold out_result and out_flags stable while out_valid = 1 and out_ready = 0.

Reset
REQ-029 SHALL, on rst = 1, immediately and asynchronously clear the pointers, set count = 0, and clear sticky_v to 0.
REQ-030 SHALL, while rst = 1, drive in_ready = 0 and out_valid = 0 and out_result = out_flags = 0; in_ready SHALL rise on the first edge after deassertion.
REQ-031 SHALL discard buffered entries when reset is applied mid-operation; entry storage need not be cleared.

Configuration
REQ-032 SHALL, with ALU_STICKY_OVF_EN defined, set sticky_v to 1 on any push with in_overflow = 1 and hold it until clr_sticky = 1; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-033 SHALL, without ALU_STICKY_OVF_EN, keep the sticky_v port, tie it to 0, and ignore clr_sticky.

Structure
REQ-034 SHALL use shared package alu_pkg for DATA_W, FLAG_W = 4, the flag bit index constants (FLAG_N, FLAG_Z, FLAG_C, FLAG_V), and the entry typedef (result word plus flags).
REQ-035 SHALL instantiate one combinational sub-module, alu_flag_gen, which maps sum/carry/overflow to {N,Z,C,V}.

Verification
REQ-036 SHALL cover this case: push sum 0x0000, C = 1, V = 0 into the empty buffer -> the next cycle gives out_valid = 1, out_result = 0x0000, out_flags = 4'b0110.
REQ-037 SHALL cover this case: push 0x7FFF, 0x8000, 0x0001, 0xFFFF with out_ready = 0 -> count = 4 and in_ready = 0; then pop -> 0x7FFF, 0x8000, 0x0001, 0xFFFF are returned in that order, with N = 0, 1, 0, 1 respectively.
REQ-038 SHALL cover this case: full buffer with in_valid = 1 and out_ready = 1 -> one pop and no push; count goes 4 to 3; in_ready = 1 the next cycle.
REQ-039 SHALL cover this case: continuous push and pop for 10 cycles with sums 1 to 10 -> count stays 1 and the outputs arrive in order across pointer wrap.
REQ-040 SHALL cover this case: with ALU_STICKY_OVF_EN, push V = 1 and clr_sticky = 1 in the same cycle -> sticky_v = 1; clr_sticky alone next cycle -> sticky_v = 0.
REQ-041 SHALL cover this case: assert rst mid-stream with count = 3 -> out_valid = 0 and count = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, flag bit indices and the buffered entry type
package alu_pkg;
    localparam int DATA_W = 16;
    localparam int FLAG_W = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [FLAG_W-1:0] flags;
    } entry_t;
endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: maps adder/subtractor sum, carry and overflow to {N,Z,C,V}
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int SUM_W = DATA_W
) (
    input  logic [SUM_W-1:0]  sum,
    input  logic              carry,
    input  logic              overflow,
    output logic [FLAG_W-1:0] flags
);
    // Flag bits are placed by index so the packing lives in the package only
    always_comb begin
        flags         = '0;
        flags[FLAG_N] = sum[SUM_W-1];
        flags[FLAG_Z] = (sum == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = overflow;
    end
endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: FIFO of ALU results with flags; ALU_STICKY_OVF_EN enables sticky overflow
module alu_result_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_sum,
    input  logic                        in_carry,
    input  logic                        in_overflow,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_result,
    output logic [alu_pkg::FLAG_W-1:0]  out_flags,
    output logic [$clog2(DEPTH):0]      count,
    input  logic                        clr_sticky,
    output logic                        sticky_v
);
    import alu_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_result [DEPTH];
    logic [FLAG_W-1:0] mem_flags  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FLAG_W-1:0] new_flags;
    logic              ready_en;
    logic              push;
    logic              pop;

    alu_flag_gen #(.SUM_W(DATA_W)) u_flag_gen (
        .sum      (in_sum),
        .carry    (in_carry),
        .overflow (in_overflow),
        .flags    (new_flags)
    );

    // ready_en keeps in_ready low until the first edge after reset releases
    assign in_ready   = ready_en && (count < CNT_W'(DEPTH));
    assign out_valid  = (count != '0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign out_result = out_valid ? mem_result[rd_ptr] : '0;
    assign out_flags  = out_valid ? mem_flags[rd_ptr] : '0;

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry storage is not reset; stale slots are unreachable once count is cleared
    always_ff @(posedge clk) begin
        if (push) begin
            mem_result[wr_ptr] <= in_sum;
            mem_flags[wr_ptr]  <= new_flags;
        end
    end

`ifdef ALU_STICKY_OVF_EN
    // Overflow on a push sets the sticky bit and beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sticky_v <= 1'b0;
        else if (push && in_overflow) sticky_v <= 1'b1;
        else if (clr_sticky) sticky_v <= 1'b0;
    end
`else
    logic unused_clr_sticky;
    assign unused_clr_sticky = clr_sticky;
    assign sticky_v          = 1'b0;
`endif
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: scoreboard bench for alu_result_buffer
module tb_alu_result_buffer;
    import alu_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [15:0]              in_sum = '0;
    logic                     in_carry = 1'b0;
    logic                     in_overflow = 1'b0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [15:0]              out_result;
    logic [3:0]               out_flags;
    logic [2:0]               count;
    logic                     clr_sticky = 1'b0;
    logic                     sticky_v;

    int     checks = 0;
    int     errors = 0;
    entry_t exp_q[$];

    alu_result_buffer #(.DEPTH(4), .DATA_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sum      (in_sum),
        .in_carry    (in_carry),
        .in_overflow (in_overflow),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags),
        .count       (count),
        .clr_sticky  (clr_sticky),
        .sticky_v    (sticky_v)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic entry_t model(input logic [15:0] s, input logic c, input logic v);
        entry_t e;
        e.result = s;
        e.flags  = {s[15], s == 16'h0000, c, v};
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [15:0] s, input logic c, input logic v, input logic rdy);
        in_valid    = vld;
        in_sum      = s;
        in_carry    = c;
        in_overflow = v;
        out_ready   = rdy;
        step();
    endtask

    // Scoreboard: inputs are stable at the falling edge, so handshakes seen here fire on the next rise
    always @(negedge clk) begin
        if (!rst) begin
            check("count", 32'(count), 32'(exp_q.size()));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() == 0) begin
                check("empty_out", 32'({out_result, out_flags}), 32'(0));
            end else begin
                check("head_result", 32'(out_result), 32'(exp_q[0].result));
                check("head_flags", 32'(out_flags), 32'(exp_q[0].flags));
            end
            if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) exp_q.push_back(model(in_sum, in_carry, in_overflow));
        end
    end

    initial begin
        logic [15:0] vals [4];
        vals[0] = 16'h7FFF;
        vals[1] = 16'h8000;
        vals[2] = 16'h0001;
        vals[3] = 16'hFFFF;

        // Reset state
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_count", 32'(count), 32'(0));
        check("rst_sticky", 32'(sticky_v), 32'(0));
        rst = 1'b0;
        #1;
        check("ready_before_edge", 32'(in_ready), 32'(0));
        step();
        check("ready_after_edge", 32'(in_ready), 32'(1));

        // Empty buffer ignores out_ready
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        check("empty_pop_count", 32'(count), 32'(0));

        // Zero sum with carry: flags N=0 Z=1 C=1 V=0
        drive(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        check("zero_valid", 32'(out_valid), 32'(1));
        check("zero_result", 32'(out_result), 32'(16'h0000));
        check("zero_flags", 32'(out_flags), 32'(4'b0110));
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Fill to full, hold, then drain in order
        for (int i = 0; i < 4; i++) drive(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        check("full_count", 32'(count), 32'(4));
        check("full_in_ready", 32'(in_ready), 32'(0));
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        check("hold_result", 32'(out_result), 32'(16'h7FFF));
        for (int i = 0; i < 4; i++) begin
            check("drain_n", 32'(out_flags[FLAG_N]), 32'(i % 2));
            drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        end

        // Full with push and pop offered: only the pop happens
        for (int i = 0; i < 4; i++) drive(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("full_pop_count", 32'(count), 32'(3));
        check("full_pop_ready", 32'(in_ready), 32'(1));
        for (int i = 0; i < 3; i++) drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Streaming push and pop across pointer wrap
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 16'(i), 1'b0, 1'b0, 1'b1);
            check("stream_count", 32'(count), 32'(1));
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        check("stream_drained", 32'(count), 32'(0));

`ifdef ALU_STICKY_OVF_EN
        in_valid = 1'b1; in_sum = 16'h8000; in_carry = 1'b1; in_overflow = 1'b1; out_ready = 1'b1; clr_sticky = 1'b1;
        step();
        in_valid = 1'b0;
        check("sticky_set_wins", 32'(sticky_v), 32'(1));
        step();
        clr_sticky = 1'b0;
        check("sticky_cleared", 32'(sticky_v), 32'(0));
`else
        drive(1'b1, 16'h8000, 1'b1, 1'b1, 1'b1);
        in_valid = 1'b0;
        check("sticky_tied_low", 32'(sticky_v), 32'(0));
        step();
`endif
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) drive(1'b1, 16'h0A00 + 16'(i), 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        check("pre_rst_count", 32'(count), 32'(3));
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("async_rst_valid", 32'(out_valid), 32'(0));
        check("async_rst_count", 32'(count), 32'(0));
        check("async_rst_out", 32'({out_result, out_flags}), 32'(0));
        check("async_rst_ready", 32'(in_ready), 32'(0));
        step();
        rst = 1'b0;
        step();
        check("post_rst_ready", 32'(in_ready), 32'(1));
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
